// File: rtl/mant_mult_sched.sv
// Round-robin share of one mantissa multiplier between two requesters; operands held MULT_LAT cycles, response MULT_LAT+1 after accept.
// Backpressure: resp_ready low parks the response and blocks both requesters; no grant in the cycle a response is taken.
module mant_mult_sched #(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [30:0] req0_a,
  input  logic [30:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [30:0] req1_a,
  input  logic [30:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [22:0] resp_mantissa,
  output logic        resp_normalised,
  output logic [30:0] mult_a_operand,
  output logic [30:0] mult_b_operand,
  input  logic        mult_normalised,
  input  logic [22:0] mult_product_mantissa,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [3:0]  cnt_q;
  logic        id_q;
  logic [30:0] op_a_q, op_b_q;
  logic [22:0] mant_q;
  logic        norm_q;
  logic        grant0, grant1, accept, capture;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the requester not served last wins.
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
        if (grant0 || grant1) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = grant0 || grant1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      id_q         <= 1'b0;
      op_a_q       <= 31'd0;
      op_b_q       <= 31'd0;
      mant_q       <= 23'd0;
      norm_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q       <= grant1 ? req1_a : req0_a;
        op_b_q       <= grant1 ? req1_b : req0_b;
        id_q         <= grant1;
        last_grant_q <= grant1;
        cnt_q        <= CNT_LOAD;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        mant_q <= mult_product_mantissa;
        norm_q <= mult_normalised;
      end
    end
  end

  assign req0_ready      = grant0;
  assign req1_ready      = grant1;
  assign resp_valid      = (state_q == RESP);
  assign resp_id         = id_q;
  assign resp_mantissa   = mant_q;
  assign resp_normalised = norm_q;
  assign mult_a_operand  = op_a_q;
  assign mult_b_operand  = op_b_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mant_mult_sched.sv
// Bench for mant_mult_sched: a MULT_LAT=1 and a MULT_LAT=4 instance share stimulus, each with an XOR multiplier stub.
module tb_mant_mult_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid, resp_ready, flip;
  logic [30:0] req0_a, req0_b, req1_a, req1_b;

  logic [1:0]  r0_rdy, r1_rdy, rv, rid, rnorm, bsy, mnorm;
  logic [22:0] rmant [2];
  logic [22:0] mmant [2];
  logic [30:0] ma [2];
  logic [30:0] mb [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign mmant[g] = ma[g][22:0] ^ mb[g][22:0] ^ {23{flip}};
    assign mnorm[g] = ma[g][0] ^ flip;
    mant_mult_sched #(.MULT_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .req0_valid            (req0_valid),
      .req0_ready            (r0_rdy[g]),
      .req0_a                (req0_a),
      .req0_b                (req0_b),
      .req1_valid            (req1_valid),
      .req1_ready            (r1_rdy[g]),
      .req1_a                (req1_a),
      .req1_b                (req1_b),
      .resp_valid            (rv[g]),
      .resp_ready            (resp_ready),
      .resp_id               (rid[g]),
      .resp_mantissa         (rmant[g]),
      .resp_normalised       (rnorm[g]),
      .mult_a_operand        (ma[g]),
      .mult_b_operand        (mb[g]),
      .mult_normalised       (mnorm[g]),
      .mult_product_mantissa (mmant[g]),
      .busy                  (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (lat inst %0d): got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Job-level model: a job occupies the block from acceptance until its response is taken;
  // the result is whatever the stub shows MULT_LAT cycles after acceptance.
  int          cyc = 0;
  bit          seen_rst = 1'b0;
  int          m_acc [2];
  bit          m_act [2];
  bit          m_lg [2];
  bit          m_fresh [2];
  bit          m_id [2];
  bit          m_norm [2];
  logic [30:0] m_a [2];
  logic [30:0] m_b [2];
  logic [22:0] m_mant [2];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int lat;
      bit ev, g0, g1;
      lat = (k == 0) ? 1 : 4;
      ev  = m_act[k] && (cyc >= m_acc[k] + lat + 1);
      g0  = !m_act[k] && req0_valid && (!req1_valid || m_lg[k]);
      g1  = !m_act[k] && req1_valid && (!req0_valid || !m_lg[k]);
      if (seen_rst) begin
        chk("m_req0_ready", k, 32'(r0_rdy[k]), 32'(g0));
        chk("m_req1_ready", k, 32'(r1_rdy[k]), 32'(g1));
        chk("m_busy", k, 32'(bsy[k]), 32'(m_act[k]));
        chk("m_resp_valid", k, 32'(rv[k]), 32'(ev));
        chk("m_mult_a", k, 32'(ma[k]), 32'(m_a[k]));
        chk("m_mult_b", k, 32'(mb[k]), 32'(m_b[k]));
        if (ev || m_fresh[k]) begin
          chk("m_resp_id", k, 32'(rid[k]), 32'(m_id[k]));
          chk("m_resp_mant", k, 32'(rmant[k]), 32'(m_mant[k]));
          chk("m_resp_norm", k, 32'(rnorm[k]), 32'(m_norm[k]));
        end
      end
      if (!rst_n) begin
        m_act[k] = 1'b0; m_lg[k] = 1'b1; m_fresh[k] = 1'b1; m_id[k] = 1'b0;
        m_a[k] = '0; m_b[k] = '0; m_mant[k] = '0; m_norm[k] = 1'b0; m_acc[k] = 0;
      end else begin
        if (m_act[k] && cyc == m_acc[k] + lat) begin
          m_mant[k] = m_a[k][22:0] ^ m_b[k][22:0] ^ {23{flip}};
          m_norm[k] = m_a[k][0] ^ flip;
        end
        if (ev && resp_ready) m_act[k] = 1'b0;
        if (g0 || g1) begin
          m_act[k] = 1'b1; m_acc[k] = cyc; m_id[k] = g1; m_lg[k] = g1; m_fresh[k] = 1'b0;
          m_a[k] = g1 ? req1_a : req0_a;
          m_b[k] = g1 ? req1_b : req0_b;
        end
      end
    end
    if (!rst_n) seen_rst = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; flip = 1'b0; resp_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  int gq[$];
  int iq[$];
  int mq[$];
  int exp_g [4] = '{0, 1, 0, 1};
  int exp_m [4] = '{1, 2, 1, 2};

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1; flip = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
      chk("rst_resp_valid", k, 32'(rv[k]), 32'd0);
      chk("rst_mult_a", k, 32'(ma[k]), 32'd0);
    end

    // Single job
    step(); req0_valid = 1'b1; req0_a = 31'h5; req0_b = 31'h3;
    @(negedge clk);
    chk("single_req0_ready", 0, 32'(r0_rdy[0]), 32'd1);
    step(); req0_valid = 1'b0;
    @(negedge clk);
    chk("single_mult_a", 0, 32'(ma[0]), 32'h5);
    step();
    @(negedge clk);
    chk("single_resp_valid", 0, 32'(rv[0]), 32'd1);
    chk("single_resp_mant", 0, 32'(rmant[0]), 32'h6);
    chk("single_resp_norm", 0, 32'(rnorm[0]), 32'd1);
    chk("single_resp_id", 0, 32'(rid[0]), 32'd0);
    repeat (6) step();

    // Contention
    do_reset();
    step();
    req0_valid = 1'b1; req0_a = 31'h1; req0_b = 31'h0;
    req1_valid = 1'b1; req1_a = 31'h2; req1_b = 31'h0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (r0_rdy[0]) gq.push_back(0);
      if (r1_rdy[0]) gq.push_back(1);
      if (rv[0] && resp_ready) begin
        iq.push_back(int'(rid[0]));
        mq.push_back(int'(rmant[0]));
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_grant_count", 0, 32'(gq.size()), 32'd5);
    chk("cont_resp_count", 0, 32'(iq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", 0, (i < gq.size()) ? 32'(gq[i]) : 32'hEE, 32'(exp_g[i]));
      chk("cont_resp_id", 0, (i < iq.size()) ? 32'(iq[i]) : 32'hEE, 32'(exp_g[i]));
      chk("cont_resp_mant", 0, (i < mq.size()) ? 32'(mq[i]) : 32'hEE, 32'(exp_m[i]));
    end
    repeat (8) step();

    // Latency with a glitching stub
    do_reset();
    step(); req0_valid = 1'b1; req0_a = 31'h12; req0_b = 31'h34;
    step(); req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_busy_t1", 1, 32'(bsy[1]), 32'd1);
    step(); flip = 1'b1;
    step(); flip = 1'b0;
    @(negedge clk);
    chk("lat_valid_t3", 1, 32'(rv[1]), 32'd0);
    step(); flip = 1'b1;
    @(negedge clk);
    chk("lat_valid_t4", 1, 32'(rv[1]), 32'd0);
    step(); flip = 1'b0;
    @(negedge clk);
    chk("lat_valid_t5", 1, 32'(rv[1]), 32'd1);
    chk("lat_resp_mant", 1, 32'(rmant[1]), 32'h7FFFD9);
    chk("lat_resp_norm", 1, 32'(rnorm[1]), 32'd1);
    repeat (3) step();

    // Back-pressure
    do_reset();
    step(); resp_ready = 1'b0; req0_valid = 1'b1; req0_a = 31'h0ABCDE; req0_b = 31'h012345;
    step(); req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 31'h155; req1_b = 31'h0AA;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("bp_req1_ready", 0, 32'(r1_rdy[0]), 32'd0);
      chk("bp_resp_valid", 0, 32'(rv[0]), 32'd1);
      chk("bp_resp_mant", 0, 32'(rmant[0]), 32'h0B9F9B);
    end
    step(); resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req1_ready", 0, 32'(r1_rdy[0]), 32'd0);
    step();
    @(negedge clk);
    chk("bp_idle_req1_ready", 0, 32'(r1_rdy[0]), 32'd1);
    chk("bp_idle_busy", 0, 32'(bsy[0]), 32'd0);
    step(); req1_valid = 1'b0;
    repeat (8) step();

    // Reset mid-job
    do_reset();
    step(); req0_valid = 1'b1; req0_a = 31'h33; req0_b = 31'h11;
    step(); req0_valid = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_resp_valid", k, 32'(rv[k]), 32'd0);
      chk("mid_rst_busy", k, 32'(bsy[k]), 32'd0);
      chk("mid_rst_mult_a", k, 32'(ma[k]), 32'd0);
      chk("mid_rst_mult_b", k, 32'(mb[k]), 32'd0);
      chk("mid_rst_resp_mant", k, 32'(rmant[k]), 32'd0);
    end
    step();
    req0_valid = 1'b1; req0_a = 31'h1; req0_b = 31'h0;
    req1_valid = 1'b1; req1_a = 31'h2; req1_b = 31'h0;
    @(negedge clk);
    chk("mid_rst_first_req0", 0, 32'(r0_rdy[0]), 32'd1);
    chk("mid_rst_first_req1", 0, 32'(r1_rdy[0]), 32'd0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) step();

    // Input churn after acceptance
    do_reset();
    step(); req0_valid = 1'b1; req0_a = 31'hAA; req0_b = 31'h55;
    step(); req0_valid = 1'b0; req0_a = 31'h123;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("churn_mult_a", 1, 32'(ma[1]), 32'hAA);
      step();
      req0_a = req0_a + 31'd1;
    end
    @(negedge clk);
    chk("churn_resp_valid", 1, 32'(rv[1]), 32'd1);
    chk("churn_resp_mant", 1, 32'(rmant[1]), 32'hFF);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
